// File: rtl/servo_waypoint_sequencer.sv
// rtl/servo_waypoint_sequencer.sv - records pan/tilt waypoints and replays them as a slewed, dwelled sequence
// Transparent in IDLE; in SLEW/DWELL the duty outputs track the stored waypoint list.
module servo_waypoint_sequencer #(
    parameter int DEPTH       = 8,
    parameter int STEP_TICKS  = 500000,
    parameter int DWELL_TICKS = 25000000,
    parameter int CW          = 25
) (
    input  logic                       sysclk,
    input  logic                       reset,
    input  logic [5:0]                 pos_x_in,
    input  logic [5:0]                 pos_y_in,
    input  logic                       record,
    input  logic                       clear,
    input  logic                       play,
    input  logic                       stop,
    input  logic                       loop_en,
    output logic [5:0]                 duty_x,
    output logic [5:0]                 duty_y,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     wp_count,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SLEW, DWELL} state_t;

    state_t          r_state;
    logic [AW:0]     r_wp_count;
    logic [AW-1:0]   r_idx;
    logic [CW-1:0]   r_tick;
    logic [CW-1:0]   r_dwell;
    logic [5:0]      r_duty_x;
    logic [5:0]      r_duty_y;
    logic [11:0]     r_mem [DEPTH];

    logic [11:0]     w_tgt;
    logic [5:0]      w_tgt_x;
    logic [5:0]      w_tgt_y;
    logic [5:0]      w_next_x;
    logic [5:0]      w_next_y;
    logic            w_full;
    logic            w_at_tgt;
    logic            w_step;
    logic            w_dwell_done;
    logic            w_last;
    logic            w_wr_en;

    assign w_tgt        = r_mem[r_idx];
    assign w_tgt_x      = w_tgt[11:6];
    assign w_tgt_y      = w_tgt[5:0];
    assign w_full       = (r_wp_count == (AW+1)'(DEPTH));
    assign w_at_tgt     = (r_duty_x == w_tgt_x) && (r_duty_y == w_tgt_y);
    assign w_step       = (r_tick == CW'(STEP_TICKS - 1));
    assign w_dwell_done = (r_dwell == CW'(DWELL_TICKS - 1));
    assign w_last       = ({1'b0, r_idx} == r_wp_count - (AW+1)'(1));
    assign w_wr_en      = (r_state == IDLE) && !clear && record && !w_full;

    // Saturating single-LSB approach; equality holds, so no overshoot or wrap.
    assign w_next_x = (r_duty_x < w_tgt_x) ? r_duty_x + 6'd1 :
                      (r_duty_x > w_tgt_x) ? r_duty_x - 6'd1 : r_duty_x;
    assign w_next_y = (r_duty_y < w_tgt_y) ? r_duty_y + 6'd1 :
                      (r_duty_y > w_tgt_y) ? r_duty_y - 6'd1 : r_duty_y;

    always_ff @(posedge sysclk) begin
        if (w_wr_en) begin
            r_mem[r_wp_count[AW-1:0]] <= {pos_x_in, pos_y_in};
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wp_count <= '0;
            r_idx      <= '0;
            r_tick     <= '0;
            r_dwell    <= '0;
            r_duty_x   <= 6'd32;
            r_duty_y   <= 6'd32;
        end else begin
            case (r_state)
                IDLE: begin
                    r_duty_x <= pos_x_in;
                    r_duty_y <= pos_y_in;
                    if (clear) begin
                        r_wp_count <= '0;
                    end else if (record) begin
                        if (!w_full) r_wp_count <= r_wp_count + (AW+1)'(1);
                    end else if (play && (r_wp_count != '0)) begin
                        r_idx   <= '0;
                        r_tick  <= '0;
                        r_state <= SLEW;
                    end
                end
                SLEW: begin
                    if (stop) begin
                        r_state <= IDLE;
                    end else if (w_at_tgt) begin
                        r_dwell <= '0;
                        r_state <= DWELL;
                    end else if (w_step) begin
                        r_tick   <= '0;
                        r_duty_x <= w_next_x;
                        r_duty_y <= w_next_y;
                    end else begin
                        r_tick <= r_tick + CW'(1);
                    end
                end
                DWELL: begin
                    if (stop) begin
                        r_state <= IDLE;
                    end else if (w_dwell_done) begin
                        r_tick <= '0;
                        if (!w_last) begin
                            r_idx   <= r_idx + AW'(1);
                            r_state <= SLEW;
                        end else if (loop_en) begin
                            r_idx   <= '0;
                            r_state <= SLEW;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_dwell <= r_dwell + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign duty_x   = r_duty_x;
    assign duty_y   = r_duty_y;
    assign busy     = (r_state != IDLE);
    assign wp_count = r_wp_count;
    assign full     = w_full;
endmodule
